bp_update_ctrl: RTL
===================

// Module: bp_update_ctrl
// PURPOSE
// Sole write-port controller for the fetch-stage branch predictor tables (gshare BHT + BTB).
// - After reset or flush: sweeps every table entry to its initial value.
// - Queues branch-resolution updates from the BEU in a small FIFO, then drains them one per cycle.
// - BHT updates are saturating read-modify-write.
// - Gates fetch predictions via pred_enable until the tables are valid.
// PARAMETERS
// IDX_W       5      table index width; BHT and BTB each have 2**IDX_W entries
// FIFO_DEPTH  4      update queue depth, power of two, >=2
// BHT_INIT    2'b11  2-bit counter value written to every BHT entry during the init sweep
// PORTS
// clk              in   1                  clock
// reset_n          in   1                  reset
// flush_req        in   1                  discard queued updates and re-run the init sweep
// upd_valid        in   1                  update request valid
// upd_ready        out  1                  update request accepted when upd_valid && upd_ready
// upd_bht_idx      in   IDX_W              shared (pc^ghr) BHT index of the resolved branch
// upd_taken        in   1                  actual branch outcome: 1 increments the counter, 0 decrements it
// upd_btb_write    in   1                  also write the BTB entry (taken and redirected)
// upd_btb_idx      in   IDX_W              BTB index (pc[IDX_W:1])
// upd_target       in   32                 resolved target address
// wr_stall         in   1                  table port busy this cycle; no drain
// bht_we           out  1                  BHT write enable
// bht_idx          out  IDX_W              BHT index, used for both read and write
// bht_rdata        in   2                  combinational BHT read at bht_idx
// bht_wdata        out  2                  BHT write data
// btb_we           out  1                  BTB write enable
// btb_idx          out  IDX_W              BTB write index
// btb_wdata        out  32                 BTB target write data
// btb_valid_wdata  out  1                  BTB valid-bit write data
// pred_enable      out  1                  1 = tables valid; fetch treats every prediction as not-taken while 0
// fifo_count       out  $clog2(FIFO_DEPTH+1)  number of queued entries
// BEHAVIOUR
// - Reset: synchronous, active-low, clk/reset_n.
//   - While reset_n=0 every output is 0.
//   - Internal state on release: state=INIT, sweep cnt=0, FIFO empty.
// - States:
//   - INIT: each cycle bht_we=1, bht_idx=cnt, bht_wdata=BHT_INIT.
//     Same cycle btb_we=1, btb_idx=cnt, btb_wdata=0, btb_valid_wdata=0. Then cnt++.
//     wr_stall is ignored in INIT.
//     After the write at cnt=2**IDX_W-1 the block moves to RUN, so the sweep lasts exactly 2**IDX_W cycles.
//   - RUN: pred_enable=1. If the FIFO is not empty and wr_stall=0, the head entry drains this cycle:
//     - bht_we=1, bht_idx=head.bht_idx.
//     - bht_wdata = sat2(bht_rdata + (taken ? +1 : -1)), clamped at 2'b11 and 2'b00.
//     - btb_we=head.btb_write; btb_idx, btb_wdata come from the head; btb_valid_wdata=1.
//     - The head pops at the clock edge.
//   - Otherwise in RUN all write enables are 0.
// - pred_enable=0 in INIT, 1 in RUN. It is a registered state decode, valid the cycle state=RUN.
// - upd_ready = (state==RUN) && !full && !flush_req. There is no same-cycle pop-through when full.
// - FIFO latency: an entry accepted at edge N drains no earlier than the cycle after N.
//   Strict FIFO order; one pop per cycle maximum.
// - Back-to-back updates to the same bht_idx are correct: each write commits at the edge,
//   and the next read sees it.
// - Simultaneous push and pop when not full: both occur and fifo_count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
// - flush_req=1, in any state:
//   - That cycle all write enables are 0 and upd_ready=0.
//   - At the edge: FIFO cleared, fifo_count=0, cnt=0, state=INIT, so pred_enable=0 the next cycle.
//   - A flush during INIT restarts the sweep from index 0.
// - Outputs are don't-care when their write enable is 0, but are driven to 0.
// TESTING
// 1 Reset release, IDX_W=5 -> 32 cycles of bht_we=1 with idx 0..31, wdata=11, btb_valid_wdata=0;
//   upd_ready=0 throughout; pred_enable=1 on cycle 33.
// 2 RUN, push {bht_idx=7, taken=1, btb_write=1, btb_idx=3, target=0x100}, bht_rdata=01 ->
//   next cycle bht_we=1, idx=7, wdata=10, btb_we=1, idx=3, wdata=0x100, valid=1.
// 3 Saturation: taken with rdata=11 -> wdata=11; not-taken with rdata=00 -> wdata=00;
//   btb_write=0 -> btb_we=0.
// 4 wr_stall=1, 5 pushes -> 4 accepted, fifo_count=4, upd_ready=0 on the 5th;
//   release the stall -> 4 in-order writes on consecutive cycles, then count=0.
// 5 Flush with 3 entries queued -> no writes that cycle, fifo_count=0 next cycle, pred_enable=0,
//   32-cycle sweep from idx 0.
// 6 Two taken updates to idx 9, table initially 00, model table responds to writes ->
//   writes 01 then 10 on consecutive cycles.

Source files
------------

// File: rtl/bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl
//   Sole write-port controller for the fetch-stage branch predictor tables
//   (gshare BHT of 2-bit counters plus a BTB of targets with valid bits).
//   After reset or a flush it sweeps every table entry to its initial value.
//   Once the tables are valid, it queues branch-resolution updates from the
//   BEU in a small FIFO and drains one per cycle. Each BHT update is a
//   saturating read-modify-write that uses the combinational table read port.
//
// Ports
//   clk, reset_n     clock; synchronous active-low reset
//   flush_req        drop queued updates and restart the init sweep
//   upd_*            update request channel (valid/ready handshake)
//   wr_stall         table port busy this cycle, so nothing drains
//   bht_we/idx/wdata BHT write port; bht_idx also addresses the read port
//   bht_rdata        combinational BHT read data at bht_idx
//   btb_we/idx/wdata BTB write port; btb_valid_wdata is the valid bit
//   pred_enable      1 when the tables hold valid contents
//   fifo_count       number of queued updates
// -----------------------------------------------------------------------------
module bp_update_ctrl #(
    parameter int         IDX_W      = 5,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] BHT_INIT   = 2'b11
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush_req,
    input  logic                            upd_valid,
    output logic                            upd_ready,
    input  logic [IDX_W-1:0]                upd_bht_idx,
    input  logic                            upd_taken,
    input  logic                            upd_btb_write,
    input  logic [IDX_W-1:0]                upd_btb_idx,
    input  logic [31:0]                     upd_target,
    input  logic                            wr_stall,
    output logic                            bht_we,
    output logic [IDX_W-1:0]                bht_idx,
    input  logic [1:0]                      bht_rdata,
    output logic [1:0]                      bht_wdata,
    output logic                            btb_we,
    output logic [IDX_W-1:0]                btb_idx,
    output logic [31:0]                     btb_wdata,
    output logic                            btb_valid_wdata,
    output logic                            pred_enable,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    typedef struct packed {
        logic [IDX_W-1:0] bht_idx;
        logic             taken;
        logic             btb_write;
        logic [IDX_W-1:0] btb_idx;
        logic [31:0]      target;
    } upd_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] cnt, cnt_next;
    logic             pred_q;

    upd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop;
    upd_t             head;
    logic [1:0]       bht_next;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];
    assign push  = upd_valid && upd_ready;

    // Saturating 2-bit counter step on the value currently in the table.
    always_comb begin
        bht_next = bht_rdata;
        if (head.taken) begin
            if (bht_rdata != 2'b11) bht_next = bht_rdata + 2'b01;
        end else begin
            if (bht_rdata != 2'b00) bht_next = bht_rdata - 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Sweep/run state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_INIT;
            cnt    <= '0;
            pred_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            // Registered decode, so pred_enable is high exactly while in RUN.
            pred_q <= (state_next == ST_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Next state and write-port outputs. Outputs are forced to zero while
    // reset is asserted, because the synchronous reset has not yet taken
    // effect on the first reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        upd_ready       = 1'b0;
        pop             = 1'b0;
        bht_we          = 1'b0;
        bht_idx         = '0;
        bht_wdata       = '0;
        btb_we          = 1'b0;
        btb_idx         = '0;
        btb_wdata       = '0;
        btb_valid_wdata = 1'b0;

        if (!reset_n) begin
            state_next = ST_INIT;
            cnt_next   = '0;
        end else if (flush_req) begin
            // A flush takes priority in every state: no writes this cycle,
            // and the sweep restarts from index 0.
            state_next = ST_INIT;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    // wr_stall is ignored; the sweep owns the port.
                    bht_we    = 1'b1;
                    bht_idx   = cnt;
                    bht_wdata = BHT_INIT;
                    btb_we    = 1'b1;
                    btb_idx   = cnt;
                    cnt_next  = cnt + IDX_W'(1);
                    if (cnt == '1) state_next = ST_RUN;
                end
                ST_RUN: begin
                    // No pop-through when full: ready depends only on the
                    // registered occupancy.
                    upd_ready = !full;
                    if (!empty && !wr_stall) begin
                        pop       = 1'b1;
                        bht_we    = 1'b1;
                        bht_idx   = head.bht_idx;
                        bht_wdata = bht_next;
                        if (head.btb_write) begin
                            btb_we          = 1'b1;
                            btb_idx         = head.btb_idx;
                            btb_wdata       = head.target;
                            btb_valid_wdata = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Update FIFO. FIFO_DEPTH is a power of two, so pointers wrap freely.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n || flush_req) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; occupancy is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{bht_idx:   upd_bht_idx,
                                   taken:     upd_taken,
                                   btb_write: upd_btb_write,
                                   btb_idx:   upd_btb_idx,
                                   target:    upd_target};
        end
    end

    assign pred_enable = reset_n && pred_q;
    assign fifo_count  = reset_n ? count : '0;

endmodule
